// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell reused LSB-first across WIDTH cycles,
// with valid/ready handshakes on the parallel operand and result sides.

module full_adder_behavioral (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic [1:0] total;

  always_comb begin
    total = 2'(a) + 2'(b) + 2'(cin);
    sum   = total[0];
    cout  = total[1];
  end
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready in the same cycle, and in_ready is
// only high in IDLE while out_valid is only high in DONE.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CNT_W-1:0] count;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  full_adder_behavioral u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit  = (count == CNT_W'(WIDTH - 1));
  assign sum       = sum_sh;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= carry_in;
      count   <= '0;
      sum_sh  <= '0;
    end else if (state == RUN) begin
      // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
      sum_sh  <= (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry_q <= fa_cout;
      count   <= count + CNT_W'(1);
      if (last_bit) begin
        cout_q <= fa_cout;
        // carry_q holds the carry into the MSB during the last bit.
        ovf_q  <= carry_q ^ fa_cout;
      end
    end
  end
endmodule
